// File: rtl/hier_fanout_node.sv
// hier_fanout_node: buffered one-to-NUM_CHILD stream fan-out, round-robin or dest-directed
// The head of the FIFO (or the input beat itself when the FIFO is empty) feeds a registered output stage.
module hier_fanout_node #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int MODE      = 0,
    localparam int CW       = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
    localparam int LW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [CW-1:0]        in_dest,
    output logic [NUM_CHILD-1:0] out_valid,
    input  logic [NUM_CHILD-1:0] out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [LW-1:0]        fifo_level,
    output logic                 route_err
);
    localparam int AW = LW - 1;
    localparam logic [CW:0] NC = (CW + 1)'(NUM_CHILD);
    localparam logic [CW-1:0] LAST = CW'(NUM_CHILD - 1);
    localparam logic [NUM_CHILD-1:0] ONE = NUM_CHILD'(1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [CW+DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic                  init_q;
    logic [CW-1:0]         rr_q, rr_d;
    logic [NUM_CHILD-1:0]  ov_q, ov_d;
    logic [DATA_W-1:0]     od_q, od_d;
    logic                  err_q, err_d;
    logic                  push, fire, from_fifo, take, pop, wr_en, head_bad;
    logic [CW-1:0]         head_dest, tgt;
    logic [DATA_W-1:0]     head_data;

    assign in_ready   = init_q && (cnt_q != FULL);
    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign fifo_level = cnt_q;
    assign route_err  = err_q;

    always_comb begin
        push      = in_valid && in_ready;
        fire      = |(ov_q & out_ready);
        from_fifo = cnt_q != '0;
        take      = (~|ov_q || fire) && (from_fifo || push);
        pop       = take && from_fifo;
        // an input beat that goes straight to the output register never occupies a FIFO slot
        wr_en     = push && !(take && !from_fifo);
        {head_dest, head_data} = from_fifo ? mem_q[rd_q] : {in_dest, in_data};
        head_bad  = (MODE == 1) && (NUM_CHILD > 1) && ({1'b0, head_dest} >= NC);
        rr_d      = !fire ? rr_q : (NUM_CHILD == 1 || rr_q == LAST) ? '0 : rr_q + CW'(1);
        tgt       = (NUM_CHILD == 1) ? '0 : (MODE == 1) ? head_dest : rr_d;
        ov_d      = take ? (head_bad ? '0 : ONE << tgt) : (fire ? '0 : ov_q);
        od_d      = (take && !head_bad) ? head_data : od_q;
        err_d     = take && head_bad;
        cnt_d     = cnt_q + LW'(wr_en) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= {in_dest, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            rr_q   <= '0;
            ov_q   <= '0;
            od_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            wr_q   <= wr_q + AW'(wr_en);
            rd_q   <= rd_q + AW'(pop);
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            err_q  <= err_d;
        end
    end
endmodule
